cache_ctrl_param: RTL and testbench

Parametrised write-back cache controller FSM for the MIPS pipeline data cache. It sequences hit writes, dirty-line write-back and line refill over a word-serial memory handshake.
- Block size is generic (2**OFFSET_W words). One beat counter replaces the unrolled per-word states.
- New over the previous generation: a request qualifier, an explicit memory read strobe, a pipeline stall output and an optional write-no-allocate mode.
- Sits between the pipeline MEM stage (Req, CWE, Suspense), the tag/data arrays (Hit, Dirty, WE, SetValid, SetDirty) and the memory model (MRE, MWE, MReady).

---
 rtl/cache_pkg.sv | 15 +
 rtl/cache_beat_cnt.sv | 33 +++
 rtl/cache_ctrl_param.sv | 132 +++++++++++++
 tb/tb_cache_ctrl_param.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the data-cache controller: FSM state encoding
// and the default block-offset width.
package cache_pkg;

  localparam int DEF_OFFSET_W = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WB   = 3'd1,
    FILL = 3'd2,
    WT   = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/cache_beat_cnt.sv
// Word-beat counter for block bursts. Counts 0 .. 2**W-1 on en and wraps
// back to 0 after the last beat. With W=0 (one-word blocks) the count is a
// constant 0 and every beat is the last one; the bus stays 1 bit wide so
// the port never becomes zero-width.
module cache_beat_cnt #(
  parameter  int W  = 2,
  localparam int CW = (W > 0) ? W : 1
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          last
);

  if (W == 0) begin : g_one
    assign cnt  = '0;
    assign last = 1'b1;
  end else begin : g_cnt
    logic [W-1:0] q;

    // Beat register: reset/clear win over counting; wraps naturally at all-ones
    always_ff @(posedge CLK) begin
      if (Reset || clr) q <= '0;
      else if (en)      q <= q + 1'b1;
    end

    assign cnt  = q;
    assign last = (q == {W{1'b1}});
  end

endmodule

// File: rtl/cache_ctrl_param.sv
// Write-back data-cache controller. Handles hit stores in place, and on a
// miss sequences an optional dirty-line write-back followed by a line
// refill, one word per MReady beat. With WRITE_ALLOC=0 a store miss becomes
// a single-word memory write and the cache is left untouched.
module cache_ctrl_param
  import cache_pkg::*;
#(
  parameter  int OFFSET_W    = DEF_OFFSET_W,
  parameter  bit WRITE_ALLOC = 1'b1,
  localparam int OW          = (OFFSET_W > 0) ? OFFSET_W : 1
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          Req,
  input  logic          CWE,
  input  logic [OW-1:0] Offset,
  input  logic          Suspense,
  input  logic          Hit,
  input  logic          Dirty,
  input  logic          MReady,
  output logic          WE,
  output logic          SetValid,
  output logic          SetDirty,
  output logic          MWE,
  output logic          MRE,
  output logic [OW-1:0] BlockOffset,
  output logic          Stall,
  output logic          Init,
  output logic          OffsetSW
);

  state_t        state, nxt;
  logic [OW-1:0] cnt;
  logic          last;
  logic          burst;

  // Only block bursts advance the beat counter; a write-through is one word
  assign burst = (state == WB) || (state == FILL);

  cache_beat_cnt #(.W(OFFSET_W)) u_cnt (
    .CLK   (CLK),
    .Reset (Reset),
    .en    (burst && MReady),
    .clr   (state == IDLE),
    .cnt   (cnt),
    .last  (last)
  );

  // State register; Reset aborts any burst in progress
  always_ff @(posedge CLK) begin
    if (Reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (Req) begin
          if (Hit)                       nxt = Suspense ? DONE : IDLE;
          else if (CWE && !WRITE_ALLOC)  nxt = WT;
          else                           nxt = Dirty ? WB : FILL;
        end
      end
      WB:      if (MReady && last) nxt = FILL;
      FILL:    if (MReady && last) nxt = DONE;
      WT:      if (MReady)         nxt = DONE;
      DONE:    if (!Suspense)      nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Output decode; arrays follow BlockOffset during bursts, CPU Offset otherwise
  always_comb begin
    WE          = 1'b0;
    SetValid    = 1'b0;
    SetDirty    = 1'b0;
    MWE         = 1'b0;
    MRE         = 1'b0;
    Stall       = 1'b0;
    Init        = 1'b0;
    OffsetSW    = 1'b0;
    BlockOffset = cnt;
    case (state)
      IDLE: begin
        Init     = 1'b1;
        OffsetSW = 1'b1;
        if (Req) begin
          if (Hit) begin
            if (CWE) begin
              WE       = 1'b1;
              SetValid = 1'b1;
              SetDirty = 1'b1;
            end
          end else begin
            Stall = 1'b1;
          end
        end
      end
      WB: begin
        Stall = 1'b1;
        MWE   = 1'b1;
      end
      FILL: begin
        Stall = 1'b1;
        MRE   = 1'b1;
        // Each returned word is written; the final one also validates the line
        if (MReady) begin
          WE       = 1'b1;
          SetValid = last;
        end
      end
      WT: begin
        Stall       = 1'b1;
        MWE         = 1'b1;
        BlockOffset = Offset;
      end
      DONE: begin
        OffsetSW = 1'b1;
        // Completes a store that was held by Suspense or waited on a refill
        if (Req && Hit && CWE && !Suspense) begin
          WE       = 1'b1;
          SetValid = 1'b1;
          SetDirty = 1'b1;
        end
      end
      default: BlockOffset = '0;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_param.sv
// Directed bench for cache_ctrl_param. A write-allocate instance is driven
// from a vector table (one record per cycle); a no-allocate instance gets
// a hand-written write-through sequence.
module tb_cache_ctrl_param;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       Reset, Req, CWE, Suspense, Hit, Dirty, MReady;
  logic [1:0] Offset;

  logic       a_we, a_sv, a_sd, a_mwe, a_mre, a_stall, a_init, a_osw;
  logic [1:0] a_bo;
  logic       b_we, b_sv, b_sd, b_mwe, b_mre, b_stall, b_init, b_osw;
  logic [1:0] b_bo;

  cache_ctrl_param #(.OFFSET_W(2), .WRITE_ALLOC(1'b1)) dut_a (
    .CLK(CLK), .Reset(Reset), .Req(Req), .CWE(CWE), .Offset(Offset),
    .Suspense(Suspense), .Hit(Hit), .Dirty(Dirty), .MReady(MReady),
    .WE(a_we), .SetValid(a_sv), .SetDirty(a_sd), .MWE(a_mwe), .MRE(a_mre),
    .BlockOffset(a_bo), .Stall(a_stall), .Init(a_init), .OffsetSW(a_osw));

  cache_ctrl_param #(.OFFSET_W(2), .WRITE_ALLOC(1'b0)) dut_b (
    .CLK(CLK), .Reset(Reset), .Req(Req), .CWE(CWE), .Offset(Offset),
    .Suspense(Suspense), .Hit(Hit), .Dirty(Dirty), .MReady(MReady),
    .WE(b_we), .SetValid(b_sv), .SetDirty(b_sd), .MWE(b_mwe), .MRE(b_mre),
    .BlockOffset(b_bo), .Stall(b_stall), .Init(b_init), .OffsetSW(b_osw));

  // {WE,SetValid,SetDirty,MWE,MRE,BlockOffset[1:0],Stall,Init,OffsetSW}
  wire [9:0] a_out = {a_we, a_sv, a_sd, a_mwe, a_mre, a_bo, a_stall, a_init, a_osw};
  wire [9:0] b_out = {b_we, b_sv, b_sd, b_mwe, b_mre, b_bo, b_stall, b_init, b_osw};

  typedef struct {
    string      name;
    logic       rst, req, cwe;
    logic [1:0] off;
    logic       sus, hit, dirty, mrdy;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [9:0] o(input logic we, sv, sd, mwe, mre,
                                   input logic [1:0] bo,
                                   input logic st, ini, osw);
    return {we, sv, sd, mwe, mre, bo, st, ini, osw};
  endfunction

  task automatic add(input string nm, input logic rst, req, cwe,
                     input logic [1:0] off, input logic sus, hit, dirty, mrdy,
                     input logic [9:0] exp);
    vec_t v;
    v.name = nm; v.rst = rst; v.req = req; v.cwe = cwe; v.off = off;
    v.sus = sus; v.hit = hit; v.dirty = dirty; v.mrdy = mrdy; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, req, cwe, input logic [1:0] off,
                       input logic sus, hit, dirty, mrdy);
    @(negedge CLK);
    Reset = rst; Req = req; CWE = cwe; Offset = off;
    Suspense = sus; Hit = hit; Dirty = dirty; MReady = mrdy;
    #1;
  endtask

  task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  logic [9:0] IDL, FILLW, DN;

  initial begin
    IDL = o(0,0,0,0,0,2'd0,0,1,1);
    DN  = o(0,0,0,0,0,2'd0,0,0,1);

    //   name             rst req cwe off  sus hit drt rdy expected
    add("reset_idle",     0,  0,  0,  2'd0, 0, 0, 0, 0, IDL);
    add("hit_store",      0,  1,  1,  2'd1, 0, 1, 0, 1, o(1,1,1,0,0,2'd0,0,1,1));
    add("hit_stays_idle", 0,  0,  0,  2'd0, 0, 0, 0, 1, IDL);
    add("hit_load",       0,  1,  0,  2'd3, 0, 1, 0, 0, IDL);
    // clean read miss, MReady every cycle
    add("rmiss_idle",     0,  1,  0,  2'd1, 0, 0, 0, 1, o(0,0,0,0,0,2'd0,1,1,1));
    for (int i = 0; i < 4; i++)
      add("rmiss_fill",   0,  1,  0,  2'd1, 0, 0, 0, 1,
          o(1, (i == 3), 0, 0, 1, 2'(i), 1, 0, 0));
    add("rmiss_done",     0,  1,  0,  2'd1, 0, 1, 0, 1, DN);
    add("rmiss_back",     0,  0,  0,  2'd0, 0, 0, 0, 1, IDL);
    // dirty read miss, write-back MReady 1,0,1,1,1
    add("dmiss_idle",     0,  1,  0,  2'd2, 0, 0, 1, 1, o(0,0,0,0,0,2'd0,1,1,1));
    add("dmiss_wb0",      0,  1,  0,  2'd2, 0, 0, 1, 1, o(0,0,0,1,0,2'd0,1,0,0));
    add("dmiss_wb_gap",   0,  1,  0,  2'd2, 0, 0, 1, 0, o(0,0,0,1,0,2'd1,1,0,0));
    add("dmiss_wb1",      0,  1,  0,  2'd2, 0, 0, 1, 1, o(0,0,0,1,0,2'd1,1,0,0));
    add("dmiss_wb2",      0,  1,  0,  2'd2, 1, 0, 1, 1, o(0,0,0,1,0,2'd2,1,0,0));
    add("dmiss_wb3",      0,  1,  0,  2'd2, 1, 0, 1, 1, o(0,0,0,1,0,2'd3,1,0,0));
    for (int i = 0; i < 4; i++)
      add("dmiss_fill",   0,  1,  0,  2'd2, 0, 0, 1, 1,
          o(1, (i == 3), 0, 0, 1, 2'(i), 1, 0, 0));
    add("dmiss_done",     0,  0,  0,  2'd0, 0, 0, 0, 1, DN);
    add("dmiss_back",     0,  0,  0,  2'd0, 0, 0, 0, 1, IDL);
    // allocating store miss, one wait state before the first word
    add("wmiss_idle",     0,  1,  1,  2'd2, 0, 0, 0, 0, o(0,0,0,0,0,2'd0,1,1,1));
    add("wmiss_wait",     0,  1,  1,  2'd2, 0, 0, 0, 0, o(0,0,0,0,1,2'd0,1,0,0));
    for (int i = 0; i < 4; i++)
      add("wmiss_fill",   0,  1,  1,  2'd2, 0, 0, 0, 1,
          o(1, (i == 3), 0, 0, 1, 2'(i), 1, 0, 0));
    add("wmiss_store",    0,  1,  1,  2'd2, 0, 1, 0, 1, o(1,1,1,0,0,2'd0,0,0,1));
    add("wmiss_back",     0,  0,  0,  2'd0, 0, 0, 0, 0, IDL);
    // hit store under Suspense
    add("sus_idle",       0,  1,  1,  2'd1, 1, 1, 0, 0, o(1,1,1,0,0,2'd0,0,1,1));
    for (int i = 0; i < 3; i++)
      add("sus_hold",     0,  1,  1,  2'd1, 1, 1, 0, 1, DN);
    add("sus_release",    0,  1,  1,  2'd1, 0, 1, 0, 0, o(1,1,1,0,0,2'd0,0,0,1));
    add("sus_back",       0,  0,  0,  2'd0, 0, 0, 0, 0, IDL);
    // reset during FILL beat 2, then a fresh miss restarts at word 0
    add("rst_idle",       0,  1,  0,  2'd0, 0, 0, 0, 1, o(0,0,0,0,0,2'd0,1,1,1));
    add("rst_fill0",      0,  1,  0,  2'd0, 0, 0, 0, 1, o(1,0,0,0,1,2'd0,1,0,0));
    add("rst_fill1",      0,  1,  0,  2'd0, 0, 0, 0, 1, o(1,0,0,0,1,2'd1,1,0,0));
    add("rst_fill2",      1,  1,  0,  2'd0, 0, 0, 0, 1, o(1,0,0,0,1,2'd2,1,0,0));
    add("rst_after",      0,  0,  0,  2'd0, 0, 0, 0, 1, IDL);
    add("rst_remiss",     0,  1,  0,  2'd0, 0, 0, 0, 0, o(0,0,0,0,0,2'd0,1,1,1));
    add("rst_restart",    0,  1,  0,  2'd0, 0, 0, 0, 0, o(0,0,0,0,1,2'd0,1,0,0));
    for (int i = 0; i < 4; i++)
      add("rst_refill",   0,  1,  0,  2'd0, 0, 0, 0, 1,
          o(1, (i == 3), 0, 0, 1, 2'(i), 1, 0, 0));
    add("rst_done",       0,  0,  0,  2'd0, 0, 0, 0, 0, DN);

    // initial synchronous reset
    drive(1, 0, 0, 2'd0, 0, 0, 0, 0);
    drive(1, 0, 0, 2'd0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].cwe, tbl[i].off,
            tbl[i].sus, tbl[i].hit, tbl[i].dirty, tbl[i].mrdy);
      chk(tbl[i].name, a_out, tbl[i].exp);
    end

    // no-allocate instance: store miss at Offset=2 becomes a write-through
    drive(1, 0, 0, 2'd0, 0, 0, 0, 0);
    drive(0, 0, 0, 2'd0, 0, 0, 0, 0);
    chk("wt_reset_idle", b_out, IDL);
    drive(0, 1, 1, 2'd2, 0, 0, 1, 0);
    chk("wt_idle", b_out, o(0,0,0,0,0,2'd0,1,1,1));
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 2'd2, 0, 0, 1, (i == 2));
      chk("wt_write", b_out, o(0,0,0,1,0,2'd2,1,0,0));
    end
    drive(0, 0, 0, 2'd0, 0, 0, 0, 0);
    chk("wt_done", b_out, DN);
    drive(0, 0, 0, 2'd0, 0, 0, 0, 0);
    chk("wt_back", b_out, IDL);
    drive(0, 1, 0, 2'd3, 0, 0, 1, 0);
    chk("wt_rmiss_idle", b_out, o(0,0,0,0,0,2'd0,1,1,1));
    drive(0, 1, 0, 2'd3, 0, 0, 1, 0);
    chk("wt_rmiss_wb", b_out, o(0,0,0,1,0,2'd0,1,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
